// File: rtl/maxpool2x2_pkg.sv
// rtl/maxpool2x2_pkg.sv - shared constants and elaboration helpers for the pooling stage
package maxpool2x2_pkg;

    localparam int DEFAULT_N = 16;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Address width that never collapses to zero for a one-entry buffer.
    function automatic int addr_width(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

endpackage

// File: rtl/pool_linebuf.sv
// rtl/pool_linebuf.sv - register-array line buffer, one write port, combinational read
module pool_linebuf #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 3,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // No reset: every entry is written on an even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/maxpool2x2.sv
// rtl/maxpool2x2.sv - streaming 2x2 stride-2 max pooling with optional fused ReLU
module maxpool2x2
    import maxpool2x2_pkg::*;
#(
    parameter int N          = DEFAULT_N,
    parameter int CHANNEL    = 3,
    parameter int INPUT_SIZE = 6,
    parameter int RELU       = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 input_vld,
    input  logic [CHANNEL*N-1:0] input_din,
    input  logic                 input_end,
    output logic [CHANNEL*N-1:0] pool_dout,
    output logic                 pool_dout_vld,
    output logic                 pool_dout_end
);

    localparam int OUTPUT_SIZE = INPUT_SIZE / 2;
    localparam int BUF_AW      = addr_width(OUTPUT_SIZE);
    localparam int CW          = addr_width(INPUT_SIZE);
    localparam logic [CW-1:0] LAST = CW'(INPUT_SIZE - 1);

    function automatic logic [CHANNEL*N-1:0] lane_max(
        input logic [CHANNEL*N-1:0] a,
        input logic [CHANNEL*N-1:0] b
    );
        logic [CHANNEL*N-1:0] r;
        for (int k = 0; k < CHANNEL; k++) begin
            if ($signed(a[k*N +: N]) > $signed(b[k*N +: N])) begin
                r[k*N +: N] = a[k*N +: N];
            end else begin
                r[k*N +: N] = b[k*N +: N];
            end
        end
        return r;
    endfunction

    function automatic logic [CHANNEL*N-1:0] lane_relu(input logic [CHANNEL*N-1:0] a);
        logic [CHANNEL*N-1:0] r;
        for (int k = 0; k < CHANNEL; k++) begin
            r[k*N +: N] = a[k*N + N - 1] ? '0 : a[k*N +: N];
        end
        return r;
    endfunction

    logic [CW-1:0]        col;
    logic [CW-1:0]        row;
    logic [CHANNEL*N-1:0] hreg;
    logic [CHANNEL*N-1:0] hmax;
    logic [CHANNEL*N-1:0] pmax;
    logic [CHANNEL*N-1:0] pool_next;
    logic [CHANNEL*N-1:0] buf_rdata;
    logic [BUF_AW-1:0]    buf_addr;
    logic                 accept;
    logic                 at_last;
    logic                 buf_we;
    logic                 sync_err;

    assign accept    = ce && input_vld;
    assign at_last   = (row == LAST) && (col == LAST);
    assign buf_addr  = BUF_AW'(col >> 1);
    assign buf_we    = accept && col[0] && !row[0];
    assign hmax      = lane_max(hreg, input_din);
    assign pmax      = lane_max(buf_rdata, hmax);
    assign pool_next = (RELU != 0) ? lane_relu(pmax) : pmax;

    pool_linebuf #(
        .WIDTH(CHANNEL*N),
        .DEPTH(OUTPUT_SIZE),
        .AW   (BUF_AW)
    ) u_linebuf (
        .clk  (clk),
        .we   (buf_we),
        .addr (buf_addr),
        .wdata(hmax),
        .rdata(buf_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col           <= '0;
            row           <= '0;
            hreg          <= '0;
            pool_dout     <= '0;
            pool_dout_vld <= 1'b0;
            pool_dout_end <= 1'b0;
            sync_err      <= 1'b0;
        end else if (ce) begin
            pool_dout_vld <= 1'b0;
            pool_dout_end <= 1'b0;
            if (input_vld) begin
                if (col == LAST) begin
                    col <= '0;
                    row <= (row == LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (!col[0]) begin
                    hreg <= input_din;
                end
                if (col[0] && row[0]) begin
                    pool_dout     <= pool_next;
                    pool_dout_vld <= 1'b1;
                    pool_dout_end <= at_last;
                end
                // Misplaced end marker is only flagged; the raster counters keep running.
                sync_err <= sync_err | (input_end && !at_last);
            end
        end
    end

endmodule
